// File: rtl/gf180mcu_clkdiv_pkg.sv
// Shared types and defaults for the gated clock divider.
package gf180mcu_clkdiv_pkg;

  localparam int DIV_W_DEFAULT = 4;

  typedef enum logic [1:0] {
    STOP  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } clkdiv_state_t;

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__clkdiv_gate_hs.sv
// Ratio-change handshake: captures DIV_IN on request acceptance and emits the ACK pulse
// when the top signals that the captured ratio is being applied.
module gf180mcu_fd_sc_mcu7t5v0__clkdiv_gate_hs
  import gf180mcu_clkdiv_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEFAULT
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             i_req,
  input  logic [DIV_W-1:0] i_div,
  input  logic             i_apply_pt,
  output logic             o_pend,
  output logic [DIV_W-1:0] o_code,
  output logic             o_apply,
  output logic             o_ack
);

  logic             r_pend;
  logic             r_armed;
  logic [DIV_W-1:0] r_code;
  logic             r_ack;
  logic             w_accept;
  logic             w_apply;

  // r_armed stays low after reset or ACK until REQ has been observed low
  assign w_accept = i_req & ~r_pend & r_armed;
  assign w_apply  = r_pend & i_apply_pt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_pend  <= 1'b0;
      r_armed <= 1'b0;
      r_code  <= '0;
      r_ack   <= 1'b0;
    end else begin
      r_ack <= w_apply;
      if (w_apply) begin
        r_pend  <= 1'b0;
        r_armed <= 1'b0;
      end else begin
        if (!i_req) r_armed <= 1'b1;
        if (w_accept) begin
          r_pend <= 1'b1;
          r_code <= i_div;
        end
      end
    end
  end

  assign o_pend  = r_pend;
  assign o_code  = r_code;
  assign o_apply = w_apply;
  assign o_ack   = r_ack;

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__clkdiv_gate.sv
// Glitch-free gated clock divider, ratio N = code+2, registered Z output.
// Define CLKDIV_GATE_EDGE_CNT_EN to add the EDGE_CNT rising-edge counter port.
module gf180mcu_fd_sc_mcu7t5v0__clkdiv_gate
  import gf180mcu_clkdiv_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEFAULT
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [DIV_W-1:0] DIV_IN,
  input  logic             REQ,
  output logic             ACK,
  output logic             Z,
  output logic             STOPPED
`ifdef CLKDIV_GATE_EDGE_CNT_EN
  ,
  output logic [7:0]       EDGE_CNT
`endif
);

  clkdiv_state_t    r_state;
  clkdiv_state_t    w_state_next;
  logic [DIV_W:0]   r_cnt;
  logic [DIV_W:0]   w_cnt_next;
  logic [DIV_W:0]   w_cnt_inc;
  logic [DIV_W:0]   w_last;
  logic [DIV_W:0]   w_half;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] w_code;
  logic             r_z;
  logic             r_stopped;
  logic             w_z_next;
  logic             w_wrap;
  logic             w_inc_hi;
  logic             w_apply_pt;
  logic             w_apply;
  logic             w_pend;

  assign w_last    = {1'b0, r_div} + (DIV_W+1)'(1);
  assign w_half    = ({1'b0, r_div} + (DIV_W+1)'(2)) >> 1;
  assign w_wrap    = (r_cnt == w_last);
  assign w_cnt_inc = w_wrap ? '0 : r_cnt + (DIV_W+1)'(1);
  assign w_inc_hi  = (w_cnt_inc < w_half);

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_apply_pt   = 1'b0;
    case (r_state)
      STOP: begin
        w_apply_pt = 1'b1;
        w_cnt_next = '0;
        if (EN) w_state_next = RUN;
      end
      RUN: begin
        if (EN) begin
          w_cnt_next = w_cnt_inc;
          w_apply_pt = w_wrap;
        end else if (r_z && w_inc_hi) begin
          w_state_next = DRAIN;
          w_cnt_next   = w_cnt_inc;
        end else begin
          // Z=1 here means this edge ends the high pulse, which counts as a drain completion
          w_state_next = STOP;
          w_cnt_next   = '0;
          w_apply_pt   = r_z;
        end
      end
      DRAIN: begin
        if (w_inc_hi) begin
          w_cnt_next = w_cnt_inc;
        end else begin
          w_state_next = STOP;
          w_cnt_next   = '0;
          w_apply_pt   = 1'b1;
        end
      end
      default: begin
        w_state_next = STOP;
        w_cnt_next   = '0;
      end
    endcase
  end

  // A ratio change only lands on cnt 0, so the current half-point is valid here
  assign w_z_next = (w_state_next != STOP) && (w_cnt_next < w_half);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= STOP;
      r_cnt     <= '0;
      r_div     <= '0;
      r_z       <= 1'b0;
      r_stopped <= 1'b1;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_z       <= w_z_next;
      r_stopped <= (w_state_next == STOP);
      if (w_apply) r_div <= w_code;
    end
  end

  gf180mcu_fd_sc_mcu7t5v0__clkdiv_gate_hs #(
    .DIV_W (DIV_W)
  ) u_hs (
    .CLK        (CLK),
    .RST        (RST),
    .i_req      (REQ),
    .i_div      (DIV_IN),
    .i_apply_pt (w_apply_pt),
    .o_pend     (w_pend),
    .o_code     (w_code),
    .o_apply    (w_apply),
    .o_ack      (ACK)
  );

`ifdef CLKDIV_GATE_EDGE_CNT_EN
  logic [7:0] r_edge_cnt;

  always_ff @(posedge CLK) begin
    if (RST || w_apply) begin
      r_edge_cnt <= '0;
    end else if (w_z_next && !r_z && (r_edge_cnt != 8'hFF)) begin
      r_edge_cnt <= r_edge_cnt + 8'd1;
    end
  end

  assign EDGE_CNT = r_edge_cnt;
`endif

  assign Z       = r_z;
  assign STOPPED = r_stopped;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__clkdiv_gate.sv
// Directed and randomized checks of the gated divider against a period-position model.
module tb_gf180mcu_fd_sc_mcu7t5v0__clkdiv_gate;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       EN = 1'b0;
  logic [3:0] DIV_IN = 4'd0;
  logic       REQ = 1'b0;
  logic       ACK;
  logic       Z;
  logic       STOPPED;
`ifdef CLKDIV_GATE_EDGE_CNT_EN
  logic [7:0] EDGE_CNT;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // model: on = producing clock, fin = finishing last high pulse, pos = position in period
  bit m_on, m_fin, m_pend, m_armed, m_z, m_ack, m_stopped;
  int m_pos, m_n, m_code, m_ecnt;

  gf180mcu_fd_sc_mcu7t5v0__clkdiv_gate #(.DIV_W(4)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .EN      (EN),
    .DIV_IN  (DIV_IN),
    .REQ     (REQ),
    .ACK     (ACK),
    .Z       (Z),
    .STOPPED (STOPPED)
`ifdef CLKDIV_GATE_EDGE_CNT_EN
    ,
    .EDGE_CNT(EDGE_CNT)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got=%0d exp=%0d", tag, $time, got, exp);
    end
  endtask

  task automatic model_step();
    bit acc, app, zp;
    if (RST) begin
      m_on = 0; m_fin = 0; m_pos = 0; m_n = 2; m_pend = 0; m_armed = 0;
      m_code = 0; m_z = 0; m_ack = 0; m_stopped = 1; m_ecnt = 0;
    end else begin
      acc = REQ && !m_pend && m_armed;
      app = 0;
      zp  = m_z;
      if (!m_on) begin
        app = m_pend;
        if (EN) begin m_on = 1; m_pos = 0; end
      end else if (EN && !m_fin) begin
        m_pos = (m_pos + 1) % m_n;
        app = m_pend && (m_pos == 0);
      end else if (m_z && (m_pos + 1) < m_n / 2) begin
        m_fin = 1;
        m_pos = m_pos + 1;
      end else begin
        app = m_pend && m_z;
        m_on = 0; m_fin = 0; m_pos = 0;
      end
      if (app) begin
        m_n = m_code + 2; m_pend = 0; m_armed = 0;
      end else if (!REQ) begin
        m_armed = 1;
      end
      if (acc) begin m_pend = 1; m_code = int'(DIV_IN); end
      m_z = m_on && (m_pos < m_n / 2);
      m_stopped = !m_on;
      m_ack = app;
      if (app) m_ecnt = 0;
      else if (m_z && !zp && m_ecnt < 255) m_ecnt = m_ecnt + 1;
    end
  endtask

  // one clock: model advances with the inputs present at the edge, outputs sampled 1 ns later
  task automatic cyc();
    @(posedge CLK);
    model_step();
    #1;
    check("Z", Z, m_z);
    check("ACK", ACK, m_ack);
    check("STOPPED", STOPPED, m_stopped);
`ifdef CLKDIV_GATE_EDGE_CNT_EN
    check("EDGE_CNT", EDGE_CNT, m_ecnt);
`endif
    if (REQ && ACK) REQ = 1'b0;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic request(input logic [3:0] code);
    DIV_IN = code;
    REQ = 1'b1;
  endtask

  task automatic wait_ack(input string tag);
    int k = 0;
    while (REQ && k < 100) begin cyc(); k++; end
    if (REQ) begin check({tag, "_ack_timeout"}, 0, 1); REQ = 1'b0; end
  endtask

  task automatic wait_z_rise(input string tag);
    logic zp;
    int k;
    k = 0;
    zp = Z;
    cyc();
    while (!(Z && !zp) && k < 100) begin zp = Z; cyc(); k++; end
    if (!(Z && !zp)) check({tag, "_zrise_timeout"}, 0, 1);
  endtask

  int hi_cnt;

  initial begin
    cycles(3);
    check("rst_Z", Z, 0);
    check("rst_STOPPED", STOPPED, 1);
    check("rst_ACK", ACK, 0);

    // N=2 free run straight out of reset
    RST = 1'b0; EN = 1'b1;
    cyc();
    check("start_Z", Z, 1);
    check("start_STOPPED", STOPPED, 0);
    cycles(8);

    // N=5 requested mid-period
    cyc();
    request(4'd3);
    wait_ack("n5");
    cycles(20);

    // N=6, drop EN on the first high cycle
    request(4'd4);
    wait_ack("n6");
    wait_z_rise("n6");
    EN = 1'b0;
    hi_cnt = 1;
    for (int i = 0; i < 8; i++) begin cyc(); if (Z) hi_cnt++; end
    check("drain_high_len", hi_cnt, 3);
    check("drain_STOPPED", STOPPED, 1);

    // N=17 requested while stopped, then re-enabled
    request(4'd15);
    cycles(3);
    EN = 1'b1;
    cycles(40);

    // reset with a pending request during a high pulse
    request(4'd9);
    wait_z_rise("rst");
    RST = 1'b1; REQ = 1'b0;
    cyc();
    check("rst_mid_Z", Z, 0);
    RST = 1'b0;
    cycles(20);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(15) == 0) EN = ~EN;
      if (!REQ && $urandom_range(7) == 0) request(4'($urandom_range(15)));
      if ($urandom_range(199) == 0) begin RST = 1'b1; REQ = 1'b0; end
      cyc();
      RST = 1'b0;
    end

`ifdef CLKDIV_GATE_EDGE_CNT_EN
    EN = 1'b1; REQ = 1'b0;
    cyc();
    request(4'd0);
    wait_ack("ec_n2");
    cycles(620);
    check("edge_sat", EDGE_CNT, 255);
    request(4'd1);
    while (REQ && !ACK) cyc();
    if (ACK) check("edge_clear", EDGE_CNT, 0);
    else check("edge_clear_timeout", 0, 1);
    cycles(4);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/gf180mcu_fd_sc_mcu7t5v0__clkdiv_gate.md
GF180MCU_FD_SC_MCU7T5V0__CLKDIV_GATE -- requirements
Module: gf180mcu_fd_sc_mcu7t5v0__clkdiv_gate

Interface
REQ-001 Parameter DIV_W, default 4: width of the divide-ratio code.
REQ-002 CLK input 1: source clock; all state SHALL update on the rising edge of CLK.
REQ-003 RST input 1: synchronous, active-high reset.
REQ-004 EN input 1: run request; 1 = produce the divided clock, 0 = stop the divided clock glitch-free.
REQ-005 DIV_IN input DIV_W: new ratio code; ratio N = DIV_IN+2, range 2..2^DIV_W+1.
REQ-006 REQ input 1: ratio-change request; REQ SHALL be held high until ACK is seen.
REQ-007 ACK output 1: one-cycle pulse marking the cycle the new ratio takes effect.
REQ-008 Z output 1: registered divided clock, driven directly into the clkbuf I pin.
REQ-009 STOPPED output 1: 1 while Z is parked low and the divider is idle.

Function
REQ-010 States SHALL be STOP, RUN and DRAIN.
REQ-011 Counter CNT SHALL be DIV_W+1 bits wide, SHALL count 0..N-1 in RUN, and SHALL wrap to 0 after N-1.
REQ-012 Z SHALL be 1 for CNT < floor(N/2) and 0 otherwise (odd N: high phase one cycle shorter than low phase).
REQ-013 Z SHALL be a flop output with no combinational path from any input.
REQ-014 STOP->RUN on EN=1: on the next edge CNT SHALL be 0 and Z SHALL be 1.
REQ-015 RUN->DRAIN on EN=0 while Z=1.
REQ-016 RUN->STOP on EN=0 while Z=0.
REQ-017 DRAIN SHALL finish the current high phase and go to STOP when Z falls, so no high pulse is truncated.
REQ-018 DRAIN->RUN SHALL NOT occur; EN re-assertion SHALL be honoured only once STOP is reached.
REQ-019 In STOP, STOPPED SHALL be 1 and Z SHALL be 0.
REQ-020 A request SHALL be accepted when REQ=1 and no ACK is pending, and DIV_IN SHALL be captured at that edge.
REQ-021 In RUN, the captured ratio SHALL be applied at the edge where CNT wraps to 0, with ACK=1 for that single cycle.
REQ-022 In STOP, the captured ratio SHALL be applied on the next edge with ACK=1.
REQ-023 In DRAIN, the captured ratio SHALL be applied on entry to STOP.
REQ-024 After ACK, REQ still high SHALL NOT be re-accepted until REQ has been seen low for at least one cycle.
REQ-025 When EN falls and a request is pending in the same cycle, both SHALL proceed per REQ-015..REQ-023.

Reset
REQ-026 While RST=1, the block SHALL hold: state STOP, CNT 0, ratio code 0 (N=2), Z 0, ACK 0, STOPPED 1, pending request cleared.
REQ-027 Reset asserted mid-period SHALL force Z low on that edge, even if that truncates a high pulse.
REQ-028 A request pending when reset asserts SHALL be discarded and SHALL never be acknowledged.

Configuration
REQ-029 With CLKDIV_GATE_EDGE_CNT_EN defined, output EDGE_CNT[7:0] SHALL count Z rising edges, saturate at 255, and clear on reset or on ACK.
REQ-030 Without CLKDIV_GATE_EDGE_CNT_EN, the EDGE_CNT port and its logic SHALL be absent.

Structure
REQ-031 Package gf180mcu_clkdiv_pkg SHALL hold the state enum (STOP/RUN/DRAIN) and the DIV_W default constant.
REQ-032 Request capture and ACK generation SHALL reside in sub-module gf180mcu_fd_sc_mcu7t5v0__clkdiv_gate_hs.
REQ-033 The counter and state machine SHALL reside in the top module.

Verification
REQ-034 Reset release, EN=1, no request -> Z toggles every cycle (N=2, 1 high/1 low), STOPPED falls one cycle after EN.
REQ-035 REQ with DIV_IN=3 (N=5) mid-period -> ACK pulses exactly at the wrap; thereafter Z is 2 high/3 low, with no shortened pulse.
REQ-036 EN dropped on the first high cycle of N=6 -> Z stays high 3 cycles, then STOP; STOPPED=1 and Z=0 thereafter.
REQ-037 REQ with DIV_IN=15 (N=17) while STOPPED -> ACK on the next edge; on re-enable, Z is 8 high/9 low.
REQ-038 RST pulsed while Z=1 with a request pending -> Z=0 on that edge, no ACK ever, and N=2 after release.
REQ-039 With CLKDIV_GATE_EDGE_CNT_EN: 300 Z periods at N=2 -> EDGE_CNT=255; a following ACK clears it to 0.
